// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings and vector defaults.
// The controller imports this package so both sides agree on the pc_src codes.
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_JR     = 3'd3,
        PC_ILLOP  = 3'd4,
        PC_XADR   = 3'd5
    } pc_src_e;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC_DEFAULT = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC_DEFAULT  = 32'h8000_0008;

    // Vectors are the only selections allowed to override a stall.
    function automatic logic is_vector(input logic [2:0] sel);
        return (sel == PC_ILLOP) || (sel == PC_XADR);
    endfunction

endpackage

// File: rtl/instruction_fetch_next_pc_mux.sv
// Combinational next-PC selection; bit 31 is the supervisor bit and is never set
// by ordinary control flow, only by the vectors (and reset in the parent).
module next_pc_mux
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEFAULT,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic [2:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic unused_bits;
    assign unused_bits = ^{branch_target[31], jr_target[1:0]};

    // The increment wraps inside bits 30:0 and leaves the supervisor bit alone.
    assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PC_BRANCH: next_pc = {pc[31], branch_target[30:0]};
            PC_JUMP:   next_pc = {pc[31], pc_plus4[30:28], jump_index, 2'b00};
            PC_JR:     next_pc = {pc[31] & jr_target[31], jr_target[30:2], 2'b00};
            PC_ILLOP:  next_pc = ILLOP_VEC;
            PC_XADR:   next_pc = XADR_VEC;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, ROM addressing and the IF/ID pipeline register.
// Stall freezes PC and IF/ID except when a vector is taken; flush inserts a NOP bubble.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEFAULT,
    parameter logic [31:0] XADR_VEC  = XADR_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [2:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] ifid_instr_reg;
    logic [31:0] ifid_pc_plus4_reg;
    logic        ifid_valid_reg;
    logic        pc_load;

    next_pc_mux #(
        .ILLOP_VEC (ILLOP_VEC),
        .XADR_VEC  (XADR_VEC)
    ) u_next_pc_mux (
        .pc            (pc_reg),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .pc_plus4      (pc_plus4),
        .next_pc       (pc_next)
    );

    assign pc_load = !stall || is_vector(pc_src);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg            <= RESET_PC;
            ifid_instr_reg    <= 32'h0000_0000;
            ifid_pc_plus4_reg <= 32'h0000_0000;
            ifid_valid_reg    <= 1'b0;
        end else begin
            if (pc_load) begin
                pc_reg <= pc_next;
            end
            // Flush wins over stall; pc_plus4 is kept so the bubble still carries a sane link value.
            if (flush) begin
                ifid_instr_reg <= 32'h0000_0000;
                ifid_valid_reg <= 1'b0;
            end else if (!stall) begin
                ifid_instr_reg    <= rom_data;
                ifid_pc_plus4_reg <= pc_plus4;
                ifid_valid_reg    <= 1'b1;
            end
        end
    end

    assign pc            = pc_reg;
    assign rom_addr      = pc_reg;
    assign ifid_instr    = ifid_instr_reg;
    assign ifid_pc_plus4 = ifid_pc_plus4_reg;
    assign ifid_valid    = ifid_valid_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: hand-computed PC/IF-ID values per edge,
// with a combinational ROM whose word is a fixed function of the address.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [2:0]  pc_src;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_A5A5;
    endfunction

    assign rom_data = rom_word(rom_addr);

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s got %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] src, input logic st, input logic fl);
        pc_src = src;
        stall  = st;
        flush  = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(PC_SEQ, 1'b0, 1'b0);
        branch_target = '0;
        jump_index    = '0;
        jr_target     = '0;
        tick();
        tick();
        check_value("rst_pc", pc, 32'h8000_0000);
        check_value("rst_instr", ifid_instr, 32'h0);
        check_value("rst_pc4", ifid_pc_plus4, 32'h0);
        check_value("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check_value("rom_addr", rom_addr, 32'h8000_0000);

        // Sequential fetch after reset release
        reset = 1'b0;
        tick();
        check_value("seq1_pc", pc, 32'h8000_0004);
        check_value("seq1_valid", {31'd0, ifid_valid}, 32'd1);
        check_value("seq1_instr", ifid_instr, rom_word(32'h8000_0000));
        check_value("seq1_pc4", ifid_pc_plus4, 32'h8000_0004);
        tick();
        check_value("seq2_pc", pc, 32'h8000_0008);
        check_value("seq2_instr", ifid_instr, rom_word(32'h8000_0004));

        // jr from supervisor to a user address clears bit 31
        drive(PC_JR, 1'b0, 1'b0);
        jr_target = 32'h0000_0010;
        tick();
        check_value("jr_to_user", pc, 32'h0000_0010);

        drive(PC_JUMP, 1'b0, 1'b0);
        jump_index = 26'h000_0040;
        tick();
        check_value("jump_pc", pc, 32'h0000_0100);

        // Back to supervisor via vector, then branch keeps bit 31
        drive(PC_ILLOP, 1'b0, 1'b0);
        tick();
        check_value("illop_pc", pc, 32'h8000_0004);
        drive(PC_BRANCH, 1'b0, 1'b0);
        branch_target = 32'h0000_0020;
        tick();
        check_value("branch_pc", pc, 32'h8000_0020);

        drive(PC_JR, 1'b0, 1'b0);
        jr_target = 32'h0000_1003;
        tick();
        check_value("jr_case1", pc, 32'h0000_1000);

        drive(PC_BRANCH, 1'b0, 1'b0);
        branch_target = 32'h0000_0020;
        tick();
        check_value("branch_user", pc, 32'h0000_0020);
        drive(PC_JR, 1'b0, 1'b0);
        jr_target = 32'h8000_1000;
        tick();
        check_value("jr_case2", pc, 32'h0000_1000);
        check_value("jr_case2_instr", ifid_instr, rom_word(32'h0000_0020));

        // Stall two cycles: everything frozen
        drive(PC_SEQ, 1'b1, 1'b0);
        tick();
        tick();
        check_value("stall_pc", pc, 32'h0000_1000);
        check_value("stall_instr", ifid_instr, rom_word(32'h0000_0020));
        check_value("stall_pc4", ifid_pc_plus4, 32'h0000_0024);
        check_value("stall_valid", {31'd0, ifid_valid}, 32'd1);

        // Vector overrides stall for PC but IF/ID still holds
        drive(PC_XADR, 1'b1, 1'b0);
        tick();
        check_value("stall_xadr_pc", pc, 32'h8000_0008);
        check_value("stall_xadr_instr", ifid_instr, rom_word(32'h0000_0020));

        // Stall + flush: bubble, PC held, pc_plus4 held
        drive(PC_SEQ, 1'b1, 1'b1);
        tick();
        check_value("flush_pc", pc, 32'h8000_0008);
        check_value("flush_instr", ifid_instr, 32'h0);
        check_value("flush_valid", {31'd0, ifid_valid}, 32'd0);
        check_value("flush_pc4", ifid_pc_plus4, 32'h0000_0024);

        drive(PC_SEQ, 1'b0, 1'b0);
        tick();
        check_value("resume_pc", pc, 32'h8000_000C);
        check_value("resume_instr", ifid_instr, rom_word(32'h8000_0008));
        check_value("resume_valid", {31'd0, ifid_valid}, 32'd1);

        // Unused code 6 behaves as sequential
        drive(3'd6, 1'b0, 1'b0);
        tick();
        check_value("code6_pc", pc, 32'h8000_0010);

        // Wrap of bits 30:0 in user and supervisor space
        drive(PC_JR, 1'b0, 1'b0);
        jr_target = 32'h7FFF_FFFC;
        tick();
        check_value("pre_wrap_user", pc, 32'h7FFF_FFFC);
        drive(PC_SEQ, 1'b0, 1'b0);
        tick();
        check_value("wrap_user", pc, 32'h0000_0000);
        check_value("wrap_user_pc4", ifid_pc_plus4, 32'h0000_0000);

        drive(PC_ILLOP, 1'b0, 1'b0);
        tick();
        drive(PC_BRANCH, 1'b0, 1'b0);
        branch_target = 32'h7FFF_FFFC;
        tick();
        check_value("pre_wrap_sup", pc, 32'hFFFF_FFFC);
        drive(PC_SEQ, 1'b0, 1'b0);
        tick();
        check_value("wrap_sup", pc, 32'h8000_0000);
        check_value("wrap_sup_pc4", ifid_pc_plus4, 32'h8000_0000);

        // Reset in the middle of stall+flush with a vector requested
        tick();
        drive(PC_XADR, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        check_value("mid_rst_pc", pc, 32'h8000_0000);
        check_value("mid_rst_pc4", ifid_pc_plus4, 32'h0);
        check_value("mid_rst_valid", {31'd0, ifid_valid}, 32'd0);

        reset = 1'b0;
        drive(PC_SEQ, 1'b0, 1'b0);
        tick();
        check_value("post_rst_instr", ifid_instr, rom_word(32'h8000_0000));
        check_value("post_rst_pc", pc, 32'h8000_0004);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter ILLOP_VEC, default 32'h8000_0004, meaning the illegal-op/interrupt vector.
REQ-003 SHALL have parameter XADR_VEC, default 32'h8000_0008, meaning the exception vector.
REQ-004 SHALL use one clock and a synchronous active-high reset; clk and reset come first in the port list.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port stall, input, 1 bit: hold PC and the IF/ID register.
REQ-008 SHALL have port flush, input, 1 bit: load a bubble into IF/ID.
REQ-009 SHALL have port pc_src, input, 3 bits: next-PC select (0 seq, 1 branch, 2 jump, 3 jr, 4 illop, 5 xadr).
REQ-010 SHALL have port branch_target, input, 32 bits: resolved branch address.
REQ-011 SHALL have port jump_index, input, 26 bits: J/JAL instr_index field.
REQ-012 SHALL have port jr_target, input, 32 bits: register value for JR/JALR.
REQ-013 SHALL have port rom_addr, output, 32 bits: byte address to the instruction ROM; always equals pc.
REQ-014 SHALL have port rom_data, input, 32 bits: combinational ROM word for rom_addr.
REQ-015 SHALL have port pc, output, 32 bits: current PC.
REQ-016 SHALL have port ifid_instr, output, 32 bits: registered instruction.
REQ-017 SHALL have port ifid_pc_plus4, output, 32 bits: registered PC+4 of ifid_instr.
REQ-018 SHALL have port ifid_valid, output, 1 bit: ifid_instr is a real fetched instruction.

Function
REQ-019 SHALL compute pc_plus4 = {pc[31], pc[30:0]+4}; bit 31 (supervisor) is never changed by the increment, and bits 30:0 wrap from 7FFF_FFFC to 0.
REQ-020 SHALL select next PC as follows:
  - seq: pc_plus4
  - branch: {pc[31], branch_target[30:0]}
  - jump: {pc[31], pc_plus4[30:28], jump_index, 2'b00}
  - jr: {pc[31] & jr_target[31], jr_target[30:2], 2'b00}
  - illop: ILLOP_VEC
  - xadr: XADR_VEC
  - codes 6/7: treated as seq.
REQ-021 SHALL ensure jr can clear but never set the supervisor bit; only vectors and reset set it.
REQ-022 SHALL, each edge without reset, load pc with the next PC unless stall=1 and pc_src is not 4 or 5.
REQ-023 SHALL give vectors (pc_src 4/5) priority over stall: PC loads the vector even when stall=1.
REQ-024 SHALL, on an edge with flush=1, set ifid_instr=32'h0000_0000 (NOP), ifid_valid=0, and hold ifid_pc_plus4; flush overrides stall.
REQ-025 SHALL, on an edge with stall=1 and flush=0, hold all IF/ID outputs.
REQ-026 SHALL otherwise load ifid_instr=rom_data, ifid_pc_plus4=pc_plus4, ifid_valid=1.
REQ-027 SHALL make fetch latency exactly one cycle: the word at pc appears on ifid_instr after the next edge.
REQ-028 SHALL have no combinational path from stall, flush, or pc_src to any output.

Reset
REQ-029 SHALL, on an edge with reset=1, set pc=RESET_PC, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, overriding all other inputs.
REQ-030 SHALL make the first valid fetch after reset deasserts the word at RESET_PC.
REQ-031 SHALL, if reset asserts mid-stall or mid-flush, discard that operation; no state survives.

Structure
REQ-032 SHALL place the pc_src encodings and the three vector defaults in a shared package used by the controller.
REQ-033 SHALL implement next-PC selection as one combinational sub-module, next_pc_mux.
REQ-034 SHALL keep the PC and IF/ID registers in instruction_fetch.

Verification
REQ-035 SHALL check reset then 3 cycles with pc_src=0 -> pc sequence 8000_0000, 8000_0004, 8000_0008; ifid_valid rises one cycle after reset release.
REQ-036 SHALL check pc=0000_0010, pc_src=2, jump_index=26'h0000040 -> pc=0000_0100, bit 31 unchanged.
REQ-037 SHALL check, in two cases:
  - pc=8000_0020, pc_src=3, jr_target=0000_1003 -> pc=0000_1000
  - pc=0000_0020, jr_target=8000_1000 -> pc=0000_1000.
REQ-038 SHALL check stall=1 for 2 cycles with pc_src=0 -> pc and IF/ID frozen; with stall=1 and pc_src=5 -> pc=8000_0008 next edge.
REQ-039 SHALL check stall=1 and flush=1 together -> ifid_instr=0, ifid_valid=0, pc held.
REQ-040 SHALL check pc=7FFF_FFFC, pc_src=0 -> pc=0000_0000; pc=FFFF_FFFC -> pc=8000_0000.
